// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive port.
// Holds the bus register map, the STATUS bit positions, the receiver
// state encoding and a helper that assembles the STATUS word.
// No ports; imported by the receiver top and the testbench.
package uart_pkg;

  localparam logic [31:0] DATA_ADDR   = 32'h7000_0004;
  localparam logic [31:0] STATUS_ADDR = 32'h7000_0010;

  localparam int STAT_TX_READY  = 0;
  localparam int STAT_NONEMPTY  = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FRAME_ERR = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // This port has no transmitter, so "tx ready" is always reported as set.
  function automatic logic [31:0] status_word(input logic nonempty,
                                              input logic overrun,
                                              input logic frame_err);
    logic [31:0] w;
    w = '0;
    w[STAT_TX_READY]  = 1'b1;
    w[STAT_NONEMPTY]  = nonempty;
    w[STAT_OVERRUN]   = overrun;
    w[STAT_FRAME_ERR] = frame_err;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_port_if.sv
// Memory-mapped bus interface of the UART receive port.
// master: bus host, drives mem_valid/mem_write/mem_wmask/mem_wdata/mem_addr,
//         receives mem_rdata.
// slave : the peripheral, the reverse directions.
interface uart_rx_port_if;

  logic        mem_valid;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
    output mem_rdata
  );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO for received bytes.
// Ports: clk/rstn (synchronous, active-low), push/push_data write side,
// pop/pop_data read side (pop_data is the oldest entry, 0 when empty),
// empty/full flags, push_ok = the push this cycle is stored.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int FIFO_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic             push_ok
);

  localparam int DEPTH = 1 << FIFO_LOG2;

  logic [FIFO_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               pop_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_LOG2] != rd_ptr_q[FIFO_LOG2]) &&
                 (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);

  assign pop_ok = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in, so a full
  // FIFO still accepts the new byte.
  assign push_ok = push && (!full || pop_ok);

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q[FIFO_LOG2-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (rstn && push_ok) mem_q[wr_ptr_q[FIFO_LOG2-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_port.sv
// UART 8N1 receiver with a memory-mapped DATA/STATUS register pair.
// Ports: clk, rstn (synchronous, active-low), rx (asynchronous serial line,
// idle high), bus (uart_rx_port_if.slave, zero-wait-state access with
// registered read data), rx_irq (high while received bytes are waiting).
// Parameters: CLK_DIV clocks per serial bit (>= 4), FIFO_LOG2 log2 depth.
module uart_rx_port
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 16,
  parameter int FIFO_LOG2 = 2
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           rx,
  uart_rx_port_if.slave  bus,
  output logic           rx_irq
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);

  logic            sync1_q, sync1_d, sync2_q, sync2_d, rx_prev_q, rx_prev_d;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic [31:0]     rdata_q, rdata_d;

  logic            rx_fall, push, frame_set;
  logic            rd_access, wr_access, pop;
  logic            fifo_empty, fifo_full, fifo_push_ok;
  logic [7:0]      fifo_data;
  logic            unused_bits;

  assign unused_bits = ^{bus.mem_wmask[3:1], bus.mem_wdata[31:4],
                         bus.mem_wdata[1:0], fifo_full};

  // Falling edge seen on the synchronised line, one stage behind sync2.
  assign rx_fall = rx_prev_q && !sync2_q;

  // Receiver: the counter reloads to half a bit on the start edge so every
  // later sample lands mid-bit.
  always_comb begin
    sync1_d   = rx;
    sync2_d   = sync1_q;
    rx_prev_d = sync2_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!sync2_q) begin
            state_d   = DATA;
            cnt_d     = FULL_LOAD;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d   = {sync2_q, shift_q[7:1]};
          cnt_d     = FULL_LOAD;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (sync2_q) push = 1'b1;
          else         frame_set = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_access = bus.mem_valid && !bus.mem_write;
  assign wr_access = bus.mem_valid &&  bus.mem_write;
  assign pop       = rd_access && (bus.mem_addr == DATA_ADDR);

  // Bus side: read data is captured on every access and held between them;
  // sticky error flags are set by the receiver and cleared by write-1.
  always_comb begin
    rdata_d     = rdata_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (bus.mem_valid) begin
      rdata_d = '0;
      if (rd_access && bus.mem_addr == STATUS_ADDR)
        rdata_d = status_word(!fifo_empty, overrun_q, frame_err_q);
      else if (pop)
        rdata_d = {24'b0, fifo_data};
    end
    if (wr_access && bus.mem_addr == STATUS_ADDR && bus.mem_wmask[0]) begin
      if (bus.mem_wdata[STAT_OVERRUN])   overrun_d   = 1'b0;
      if (bus.mem_wdata[STAT_FRAME_ERR]) frame_err_d = 1'b0;
    end
    if (push && !fifo_push_ok) overrun_d   = 1'b1;
    if (frame_set)             frame_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      rx_prev_q   <= rx_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rdata_q     <= rdata_d;
    end
  end

  sync_fifo #(
    .WIDTH     (8),
    .FIFO_LOG2 (FIFO_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (shift_q),
    .pop       (pop),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .push_ok   (fifo_push_ok)
  );

  assign bus.mem_rdata = rdata_q;
  assign rx_irq        = !fifo_empty;

endmodule
